data_ram_resp: RTL

//  Responder for the CPU data-memory port (ce/we/sel/addr/data): word-organised RAM with byte-lane writes.

---
 rtl/data_ram_resp_pkg.sv | 16 +
 rtl/data_ram_resp_console_fifo.sv | 59 +++++
 rtl/data_ram_resp.sv | 118 +++++++++++
 3 files changed

// File: rtl/data_ram_resp_pkg.sv
// Shared constants and MMIO register map for the data-memory responder.
// The console window is only decoded when RAM_CONSOLE_EN is defined.
package data_ram_resp_pkg;

  localparam int          BYTE_BUS          = 8;
  localparam logic [31:0] MMIO_BASE_DEFAULT = 32'h0003_0000;

  // Word offsets inside the 16-byte MMIO window (addr_i[3:2]).
  typedef enum logic [1:0] {
    REG_CON_TX = 2'd0,
    REG_STAT   = 2'd1,
    REG_CYCLE  = 2'd2,
    REG_DROP   = 2'd3
  } mmio_reg_e;

endpackage

// File: rtl/data_ram_resp_console_fifo.sv
// Synchronous byte FIFO feeding the console sink; no bypass, so a pushed byte
// becomes visible one edge later. A push while full is accepted only if a pop frees a slot.
module console_fifo
  import data_ram_resp_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic [BYTE_BUS-1:0] push_data,
  input  logic                pop,
  output logic                full,
  output logic                empty,
  output logic [BYTE_BUS-1:0] head
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  logic [BYTE_BUS-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [DEPTH_LOG2:0]   count;
  logic                  do_push;
  logic                  do_pop;

  assign full    = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/data_ram_resp.sv
// Word-organised data RAM with byte-lane writes and same-cycle reads for the CPU MEM stage.
// Define RAM_CONSOLE_EN to add the MMIO window: console TX FIFO, status, cycle and drop counters.
module data_ram_resp
  import data_ram_resp_pkg::*;
#(
  parameter int          DEPTH_LOG2      = 14,
  parameter int          FIFO_DEPTH_LOG2 = 4,
  parameter logic [31:0] MMIO_BASE       = MMIO_BASE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  sel_i,
  output logic [31:0] data_o,
  output logic        con_valid_o,
  output logic [7:0]  con_data_o,
  input  logic        con_ready_i
);

  logic [31:0]           mem [2 ** DEPTH_LOG2];
  logic [DEPTH_LOG2-1:0] ram_idx;
  logic                  mmio_hit;
  logic [31:0]           mmio_rdata;
  logic                  ram_we;
  logic                  unused_bits;

  assign ram_idx = addr_i[DEPTH_LOG2+1:2];
  // Gating with rst discards any write presented while reset is still asserted.
  assign ram_we  = rst && ce_i && we_i && !mmio_hit;

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (ram_we && sel_i[k]) begin
        mem[ram_idx][k*BYTE_BUS +: BYTE_BUS] <= data_i[k*BYTE_BUS +: BYTE_BUS];
      end
    end
  end

  always_comb begin
    data_o = '0;
    if (rst && ce_i && !we_i) begin
      data_o = mmio_hit ? mmio_rdata : mem[ram_idx];
    end
  end

`ifdef RAM_CONSOLE_EN
  mmio_reg_e   mmio_reg;
  logic        mmio_wr;
  logic        push_req;
  logic        pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_head;
  logic [31:0] cycle_cnt;
  logic [31:0] drop_cnt;

  assign mmio_hit = (addr_i[31:4] == MMIO_BASE[31:4]);
  assign mmio_reg = mmio_reg_e'(addr_i[3:2]);
  assign mmio_wr  = rst && ce_i && we_i && mmio_hit;
  assign push_req = mmio_wr && (mmio_reg == REG_CON_TX) && sel_i[0];
  assign pop      = con_valid_o && con_ready_i;

  console_fifo #(
    .DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_console_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push_req),
    .push_data(data_i[7:0]),
    .pop      (pop),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .head     (fifo_head)
  );

  assign con_valid_o = !fifo_empty;
  assign con_data_o  = fifo_empty ? 8'h00 : fifo_head;

  // A full-FIFO push is lost only when no pop frees a slot in the same cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycle_cnt <= '0;
      drop_cnt  <= '0;
    end else begin
      cycle_cnt <= cycle_cnt + 1'b1;
      if (mmio_wr && (mmio_reg == REG_DROP)) begin
        drop_cnt <= '0;
      end else if (push_req && fifo_full && !pop && (drop_cnt != 32'hFFFF_FFFF)) begin
        drop_cnt <= drop_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    mmio_rdata = '0;
    case (mmio_reg)
      REG_CON_TX: mmio_rdata = '0;
      REG_STAT:   mmio_rdata = {30'b0, fifo_full, fifo_empty};
      REG_CYCLE:  mmio_rdata = cycle_cnt;
      REG_DROP:   mmio_rdata = drop_cnt;
      default:    mmio_rdata = '0;
    endcase
  end

  assign unused_bits = ^{addr_i[1:0], MMIO_BASE[3:0]};
`else
  assign mmio_hit    = 1'b0;
  assign mmio_rdata  = '0;
  assign con_valid_o = 1'b0;
  assign con_data_o  = 8'h00;
  assign unused_bits = ^{con_ready_i, addr_i[1:0], addr_i[31:DEPTH_LOG2+2],
                         MMIO_BASE[0], (FIFO_DEPTH_LOG2 > 0)};
`endif

endmodule
